// File: rtl/pair_triple_exerciser.sv
// Exhaustive stimulus driver for a 3-input majority detector: walks vectors 000..111,
// holds each SETTLE cycles, samples det_out once per vector and reports count/first error.
module pair_triple_exerciser #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       det_in0,
  output logic       det_in1,
  output logic       det_in2,
  input  logic       det_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] err_vec
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state, next_state;
  logic [2:0] vec;
  logic [3:0] settle_cnt;
  logic       expected;
  logic       mismatch;

  assign expected = (vec[0] & vec[1]) | (vec[0] & vec[2]) | (vec[1] & vec[2]);
  // Case inequality so an unknown detector response is scored as a failure.
  assign mismatch = (det_out !== expected);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = DRIVE;
      DRIVE:   if (settle_cnt == SETTLE_LAST) next_state = SAMPLE;
      SAMPLE:  next_state = (vec == 3'd7) ? DONE : DRIVE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    done    = (state == DONE);
    det_in0 = 1'b0;
    det_in1 = 1'b0;
    det_in2 = 1'b0;
    if (state == DRIVE || state == SAMPLE) begin
      det_in0 = vec[2];
      det_in1 = vec[1];
      det_in2 = vec[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec        <= 3'd0;
      settle_cnt <= 4'd0;
      err_count  <= 4'd0;
      err_vec    <= 3'd0;
      pass       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vec        <= 3'd0;
            settle_cnt <= 4'd0;
            err_count  <= 4'd0;
            err_vec    <= 3'd0;
            pass       <= 1'b0;
          end
        end
        DRIVE: begin
          settle_cnt <= (settle_cnt == SETTLE_LAST) ? 4'd0 : settle_cnt + 4'd1;
        end
        SAMPLE: begin
          if (mismatch) begin
            err_count <= err_count + 4'd1;
            if (err_count == 4'd0) err_vec <= vec;
          end
          // Result is registered on the last sample so it is already valid while done is high.
          if (vec != 3'd7) vec <= vec + 3'd1;
          else             pass <= (err_count == 4'd0) && !mismatch;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pair_triple_exerciser.sv
// Directed bench for pair_triple_exerciser: run-level reference model checked every cycle,
// plus literal expectations for each detector flavour, reset abort and back-to-back runs.
module tb_pair_triple_exerciser;

  localparam int S = 2;
  localparam int L = S + 1;
  localparam int RUN = 8 * L;

  logic       clk = 1'b0;
  logic       rst, start, det_out;
  logic       det_in0, det_in1, det_in2;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [2:0] err_vec;
  int         mode;

  int checks = 0;
  int errors = 0;

  pair_triple_exerciser #(.SETTLE(S)) dut (
    .clk(clk), .rst(rst), .start(start),
    .det_in0(det_in0), .det_in1(det_in1), .det_in2(det_in2),
    .det_out(det_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .err_vec(err_vec)
  );

  always #5 clk = ~clk;

  function automatic logic maj(logic [2:0] v);
    int n;
    n = int'(v[0]) + int'(v[1]) + int'(v[2]);
    return (n >= 2);
  endfunction

  // Detector flavours: 0 correct, 1 stuck-at-0, 2 AND3, 3 unknown on 101 only.
  function automatic logic resp(int md, logic [2:0] v);
    case (md)
      1:       return 1'b0;
      2:       return &v;
      3:       return (v == 3'b101) ? 1'bx : maj(v);
      default: return maj(v);
    endcase
  endfunction

  assign det_out = resp(mode, {det_in0, det_in1, det_in2});

  task automatic check(string name, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: position within a run, one step per clock.
  bit         m_run;
  int         m_pos;
  bit         m_pass;
  int         m_errc;
  int         m_errv;
  int         cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_run = 0; m_pos = 0; m_pass = 0; m_errc = 0; m_errv = 0;
    end else if (m_run) begin
      if (m_pos >= 1 && m_pos <= RUN && (m_pos % L) == 0) begin
        logic [2:0] v;
        v = 3'(m_pos / L - 1);
        if (resp(mode, v) !== maj(v)) begin
          if (m_errc == 0) m_errv = int'(v);
          m_errc++;
        end
        if (v == 3'd7) m_pass = (m_errc == 0);
      end
      if (m_pos == RUN + 1) begin
        m_run = 0; m_pos = 0;
      end else m_pos++;
    end else if (start) begin
      m_run = 1; m_pos = 1; m_pass = 0; m_errc = 0; m_errv = 0;
    end
  end

  int done_total = 0;
  int last_done_cyc = -1;
  int last_gap = 0;
  bit model_live = 0;

  always @(negedge clk) begin
    if (done) begin
      if (last_done_cyc >= 0) last_gap = cyc - last_done_cyc;
      last_done_cyc = cyc;
      done_total++;
    end
    if (model_live) begin
      int exp_vec;
      exp_vec = (m_run && m_pos <= RUN) ? (m_pos - 1) / L : 0;
      check("busy", int'(busy), int'(m_run));
      check("done", int'(done), int'(m_run && m_pos == RUN + 1));
      check("det_in", int'({det_in0, det_in1, det_in2}), exp_vec);
      check("pass", int'(pass), int'(m_pass));
      check("err_count", int'(err_count), m_errc);
      if (m_errc != 0) check("err_vec", int'(err_vec), m_errv);
    end
  end

  task automatic check_reset_vals(string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_pass"}, int'(pass), 0);
    check({tag, "_err_count"}, int'(err_count), 0);
    check({tag, "_err_vec"}, int'(err_vec), 0);
    check({tag, "_det_in"}, int'({det_in0, det_in1, det_in2}), 0);
  endtask

  // One start pulse; counts edges with the accepting edge as edge 1.
  task automatic run_once(string tag, int md, int exp_cnt, int exp_vec, int exp_pass);
    int n;
    bit seen;
    mode = md;
    @(negedge clk) start = 1'b1;
    @(posedge clk) n = 1;
    #1 start = 1'b0;
    seen = 0;
    for (int k = 0; k < RUN + 10; k++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
      @(posedge clk) n++;
    end
    check({tag, "_done_seen"}, int'(seen), 1);
    if (seen) begin
      check({tag, "_latency"}, n, RUN + 1);
      check({tag, "_err_count"}, int'(err_count), exp_cnt);
      if (exp_cnt != 0) check({tag, "_err_vec"}, int'(err_vec), exp_vec);
      check({tag, "_pass"}, int'(pass), exp_pass);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int dones_before;
    bit found;
    rst = 1'b1; start = 1'b0; mode = 0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    model_live = 1;
    @(negedge clk);

    run_once("correct", 0, 0, 0, 1);
    run_once("stuck0", 1, 4, 3'b011, 0);
    run_once("and3", 2, 3, 3'b011, 0);
    run_once("xon101", 3, 1, 3'b101, 0);

    // Abort during vector 100.
    mode = 0;
    dones_before = done_total;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    found = 0;
    for (int k = 0; k < RUN + 5; k++) begin
      @(negedge clk);
      if ({det_in0, det_in1, det_in2} == 3'b100) begin found = 1; break; end
    end
    check("abort_reached_100", int'(found), 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_no_done", done_total - dones_before, 0);
    check_reset_vals("abort");
    @(negedge clk) rst = 1'b0;
    run_once("rerun", 0, 0, 0, 1);

    // start held high: back-to-back runs.
    dones_before = done_total;
    @(negedge clk) start = 1'b1;
    repeat (3 * (RUN + 2) + 4) @(negedge clk);
    start = 1'b0;
    check("b2b_runs", int'(done_total - dones_before >= 3), 1);
    check("b2b_period", last_gap, RUN + 2);
    for (int k = 0; k < RUN + 5 && busy; k++) @(negedge clk);
    check("b2b_idle", int'(busy), 0);
    check("b2b_pass", int'(pass), 1);
    check("b2b_err_count", int'(err_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
